// File: rtl/lcd_spi_serializer_pkg.sv
// Shared definitions for the LCD SPI serializer: FSM state encoding and timing constants.
package lcd_spi_serializer_pkg;

  typedef enum logic [2:0] {
    LCD_SPI_IDLE  = 3'd0,
    LCD_SPI_SETUP = 3'd1,
    LCD_SPI_LOW   = 3'd2,
    LCD_SPI_HIGH  = 3'd3,
    LCD_SPI_HOLD  = 3'd4
  } lcd_spi_state_t;

  localparam int LCD_SPI_CLK_DIV_DEFAULT = 4;

  // A frame is CS setup + 8 low/high pairs + CS hold, in SCL half-periods.
  localparam int LCD_SPI_FRAME_DIVS = 18;

endpackage

// File: rtl/lcd_spi_clkdiv.sv
// SCL half-period divider: tick marks the last system cycle of each half-period.
module lcd_spi_clkdiv #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] div;

  // Restarts on every FSM state change so each state gets a full half-period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (clear || (div == LAST)) begin
      div <= '0;
    end else begin
      div <= div + 8'd1;
    end
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/lcd_spi_serializer.sv
// Byte-to-LCD serializer, SPI mode 3 (SCL idles high, SI sampled on SCL rise).
// Build option LCD_SPI_LSB_FIRST_EN shifts bits LSB-first; default is MSB-first.
module lcd_spi_serializer
  import lcd_spi_serializer_pkg::*;
#(
  parameter int CLK_DIV = LCD_SPI_CLK_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       convert_SI,
  input  logic       a0,
  output logic       lcd_si,
  output logic       lcd_scl,
  output logic       lcd_cs_n,
  output logic       lcd_a0,
  output logic       busy,
  output logic       done
);

`ifdef LCD_SPI_LSB_FIRST_EN
  localparam logic [2:0] FIRST_IDX = 3'd0;
  localparam logic [2:0] LAST_IDX  = 3'd7;
  localparam logic [2:0] IDX_STEP  = 3'd1;
`else
  localparam logic [2:0] FIRST_IDX = 3'd7;
  localparam logic [2:0] LAST_IDX  = 3'd0;
  localparam logic [2:0] IDX_STEP  = 3'd7;
`endif

  lcd_spi_state_t state, state_next;
  logic       req_q;
  logic       start;
  logic       tick;
  logic [7:0] shreg, shreg_d;
  logic [2:0] idx, idx_d;
  logic       si_d, scl_d, cs_n_d, a0_d, busy_d, done_d;

  assign start = convert_SI & ~req_q & (state == LCD_SPI_IDLE);

  lcd_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .clear (state_next != state),
    .tick  (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= LCD_SPI_IDLE;
      req_q    <= 1'b0;
      shreg    <= '0;
      idx      <= 3'd7;
      lcd_si   <= 1'b0;
      lcd_scl  <= 1'b1;
      lcd_cs_n <= 1'b1;
      lcd_a0   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      req_q    <= convert_SI;
      shreg    <= shreg_d;
      idx      <= idx_d;
      lcd_si   <= si_d;
      lcd_scl  <= scl_d;
      lcd_cs_n <= cs_n_d;
      lcd_a0   <= a0_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LCD_SPI_IDLE:  if (start) state_next = LCD_SPI_SETUP;
      LCD_SPI_SETUP: if (tick)  state_next = LCD_SPI_LOW;
      LCD_SPI_LOW:   if (tick)  state_next = LCD_SPI_HIGH;
      LCD_SPI_HIGH:  if (tick)  state_next = (idx == LAST_IDX) ? LCD_SPI_HOLD : LCD_SPI_LOW;
      LCD_SPI_HOLD:  if (tick)  state_next = LCD_SPI_IDLE;
      default:                  state_next = LCD_SPI_IDLE;
    endcase
  end

  // Outputs are registered; these are their values after the coming edge.
  always_comb begin
    shreg_d = shreg;
    idx_d   = idx;
    si_d    = lcd_si;
    scl_d   = lcd_scl;
    cs_n_d  = lcd_cs_n;
    a0_d    = lcd_a0;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      LCD_SPI_IDLE: begin
        if (start) begin
          shreg_d = data;
          a0_d    = a0;
          idx_d   = FIRST_IDX;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          scl_d   = 1'b1;
        end
      end
      LCD_SPI_SETUP: begin
        if (tick) begin
          scl_d = 1'b0;
          si_d  = shreg[idx];
        end
      end
      LCD_SPI_LOW: begin
        if (tick) scl_d = 1'b1;
      end
      LCD_SPI_HIGH: begin
        if (tick && (idx != LAST_IDX)) begin
          idx_d = idx + IDX_STEP;
          scl_d = 1'b0;
          si_d  = shreg[idx_d];
        end
      end
      LCD_SPI_HOLD: begin
        if (tick) begin
          cs_n_d = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        cs_n_d = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_spi_serializer.sv
// Scoreboard bench for lcd_spi_serializer at CLK_DIV=4 and CLK_DIV=1; follows LCD_SPI_LSB_FIRST_EN.
module tb_lcd_spi_serializer;

  typedef struct packed {
    logic [7:0] data;
    logic       a0;
  } frame_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [7:0] d0_data = '0;
  logic       d0_conv = 1'b0;
  logic       d0_a0   = 1'b0;
  logic       d0_si, d0_scl, d0_cs_n, d0_lcd_a0, d0_busy, d0_done;

  logic [7:0] d1_data = '0;
  logic       d1_conv = 1'b0;
  logic       d1_a0   = 1'b0;
  logic       d1_si, d1_scl, d1_cs_n, d1_lcd_a0, d1_busy, d1_done;

  int checks = 0;
  int errors = 0;

  frame_t exp0[$];
  frame_t exp1[$];
  int     exp_done[2];

  bit         in_frame   [2];
  int         low_cycles [2];
  logic [7:0] got_byte   [2];
  int         got_bits   [2];
  logic       a0_first   [2];
  bit         a0_stable  [2];
  logic       prev_scl   [2];
  int         done_count [2];

  always #5 clock = ~clock;

  lcd_spi_serializer #(.CLK_DIV(4)) dut0 (
    .clock      (clock),
    .reset      (reset),
    .data       (d0_data),
    .convert_SI (d0_conv),
    .a0         (d0_a0),
    .lcd_si     (d0_si),
    .lcd_scl    (d0_scl),
    .lcd_cs_n   (d0_cs_n),
    .lcd_a0     (d0_lcd_a0),
    .busy       (d0_busy),
    .done       (d0_done)
  );

  lcd_spi_serializer #(.CLK_DIV(1)) dut1 (
    .clock      (clock),
    .reset      (reset),
    .data       (d1_data),
    .convert_SI (d1_conv),
    .a0         (d1_a0),
    .lcd_si     (d1_si),
    .lcd_scl    (d1_scl),
    .lcd_cs_n   (d1_cs_n),
    .lcd_a0     (d1_lcd_a0),
    .busy       (d1_busy),
    .done       (d1_done)
  );

  task automatic check_output(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Bits collected in wire order land MSB-first in the captured byte.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef LCD_SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic monitor_step(input int u, input logic cs_n, input logic scl, input logic si,
                              input logic a0v, input logic done_v);
    frame_t f;
    int     k;
    int     depth;
    k = (u == 0) ? 4 : 1;
    if (!reset) begin
      if (in_frame[u]) begin
        in_frame[u] = 1'b0;
        if (u == 0 && exp0.size() > 0) f = exp0.pop_front();
        if (u == 1 && exp1.size() > 0) f = exp1.pop_front();
      end
    end else begin
      if (done_v) done_count[u]++;
      if (!in_frame[u]) begin
        if (!cs_n) begin
          in_frame[u]   = 1'b1;
          low_cycles[u] = 1;
          got_bits[u]   = 0;
          got_byte[u]   = '0;
          a0_first[u]   = a0v;
          a0_stable[u]  = 1'b1;
          prev_scl[u]   = scl;
        end
      end else if (!cs_n) begin
        low_cycles[u]++;
        if (!prev_scl[u] && scl) begin
          got_byte[u] = {got_byte[u][6:0], si};
          got_bits[u]++;
        end
        if (a0v != a0_first[u]) a0_stable[u] = 1'b0;
        prev_scl[u] = scl;
      end else begin
        in_frame[u] = 1'b0;
        depth = (u == 0) ? exp0.size() : exp1.size();
        check_output($sformatf("u%0d scoreboard depth at frame end", u), (depth > 0) ? 1 : 0, 1);
        check_output($sformatf("u%0d done at frame end", u), int'(done_v), 1);
        check_output($sformatf("u%0d cs_n low cycles", u), low_cycles[u], 18 * k);
        check_output($sformatf("u%0d scl rising edges", u), got_bits[u], 8);
        check_output($sformatf("u%0d a0 stable", u), int'(a0_stable[u]), 1);
        if (depth > 0) begin
          f = (u == 0) ? exp0.pop_front() : exp1.pop_front();
          check_output($sformatf("u%0d byte on wire", u), int'(got_byte[u]), int'(wire_order(f.data)));
          check_output($sformatf("u%0d lcd_a0", u), int'(a0_first[u]), int'(f.a0));
        end
      end
    end
  endtask

  always @(negedge clock) begin
    monitor_step(0, d0_cs_n, d0_scl, d0_si, d0_lcd_a0, d0_done);
    monitor_step(1, d1_cs_n, d1_scl, d1_si, d1_lcd_a0, d1_done);
  end

  task automatic apply_stimulus(input int u, input logic [7:0] d, input logic a,
                                input int hold, input bit expect_frame);
    frame_t f;
    f.data = d;
    f.a0   = a;
    @(negedge clock);
    if (u == 0) begin
      d0_data = d; d0_a0 = a; d0_conv = 1'b1;
      if (expect_frame) begin exp0.push_back(f); exp_done[0]++; end
    end else begin
      d1_data = d; d1_a0 = a; d1_conv = 1'b1;
      if (expect_frame) begin exp1.push_back(f); exp_done[1]++; end
    end
    repeat (hold) @(negedge clock);
    if (u == 0) d0_conv = 1'b0;
    else        d1_conv = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget);
    int n;
    n = 0;
    while ((((u == 0) ? d0_done : d1_done) !== 1'b1) && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    check_output($sformatf("u%0d done within budget", u), (n < budget) ? 1 : 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " lcd_cs_n"}, int'(d0_cs_n), 1);
    check_output({tag, " lcd_scl"}, int'(d0_scl), 1);
    check_output({tag, " lcd_si"}, int'(d0_si), 0);
    check_output({tag, " lcd_a0"}, int'(d0_lcd_a0), 0);
    check_output({tag, " busy"}, int'(d0_busy), 0);
    check_output({tag, " done"}, int'(d0_done), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int viol;
    int snap;
    logic [7:0] d;
    logic a;
    exp_done[0] = 0;
    exp_done[1] = 0;

    $display("[TB] reset and idle");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    check_output("u1 reset lcd_cs_n", int'(d1_cs_n), 1);
    reset = 1'b1;
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (d0_cs_n !== 1'b1 || d0_scl !== 1'b1 || d0_busy !== 1'b0) viol++;
    end
    check_output("idle lines quiet for 200 cycles", viol, 0);

    $display("[TB] single command byte 0xA2");
    apply_stimulus(0, 8'hA2, 1'b0, 1, 1'b1);
    check_output("busy after start", int'(d0_busy), 1);
    wait_done(0, 100);
    @(negedge clock);
    check_output("done is one cycle", int'(d0_done), 0);
    check_output("done count after 0xA2", done_count[0], exp_done[0]);

    $display("[TB] level held high, 0x5A");
    apply_stimulus(0, 8'h5A, 1'b1, 300, 1'b1);
    @(negedge clock);
    check_output("done count after held level", done_count[0], exp_done[0]);

    $display("[TB] edge while busy, then back-to-back");
    d = 8'($urandom);
    a = 1'($urandom_range(0, 1));
    apply_stimulus(0, d, a, 1, 1'b1);
    repeat (18) @(negedge clock);
    apply_stimulus(0, ~d, ~a, 1, 1'b0);
    wait_done(0, 100);
    d = 8'($urandom);
    a = 1'($urandom_range(0, 1));
    d0_data = d;
    d0_a0   = a;
    d0_conv = 1'b1;
    exp0.push_back('{data: d, a0: a});
    exp_done[0]++;
    @(negedge clock);
    check_output("restart on cycle after done", int'(d0_busy), 1);
    d0_conv = 1'b0;
    wait_done(0, 100);
    @(negedge clock);
    check_output("done count after dropped edge", done_count[0], exp_done[0]);

    $display("[TB] reset mid-frame");
    apply_stimulus(0, 8'($urandom), 1'($urandom_range(0, 1)), 1, 1'b1);
    exp_done[0]--;
    repeat (29) @(negedge clock);
    snap = done_count[0];
    @(posedge clock);
    #2 reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check_output("no done after abort", done_count[0], snap);

    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 5), 1'b1);
      wait_done(0, 100);
      repeat ($urandom_range(1, 4)) @(negedge clock);
    end
    check_output("done count after random frames", done_count[0], exp_done[0]);

    $display("[TB] CLK_DIV=1 frames");
    apply_stimulus(1, 8'hFF, 1'b1, 1, 1'b1);
    wait_done(1, 40);
    apply_stimulus(1, 8'h01, 1'b0, 1, 1'b1);
    wait_done(1, 40);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 8'($urandom), 1'($urandom_range(0, 1)), 1, 1'b1);
      wait_done(1, 40);
    end
    repeat (3) @(negedge clock);
    check_output("u1 done count", done_count[1], exp_done[1]);

    check_output("u0 scoreboard drained", exp0.size(), 0);
    check_output("u1 scoreboard drained", exp1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
